// File: rtl/ysyx_23060111_dmem_resp.sv
// Data-memory responder: word array at BASE, one request/response transaction at a time.
// Latency: response visible LATENCY cycles after the accept edge (LATENCY=1 -> the cycle right after).
// Backpressure: response held stable until m_resp_ready; strobes are not queued while m_req_ready=0.
module ysyx_23060111_dmem_resp #(
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          DEPTH   = 4096,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m_ren,
  input  logic [31:0] m_raddr,
  input  logic        m_wen,
  input  logic [31:0] m_waddr,
  input  logic [31:0] m_wdata,
  input  logic [31:0] m_wmask,
  output logic        m_req_ready,
  output logic [31:0] m_rdata,
  output logic        m_rvalid,
  output logic        m_bvalid,
  output logic        m_err,
  input  logic        m_resp_ready
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        rd_pend;
  logic        wr_pend;
  logic        err_pend;
  logic [31:0] rd_buf;

  logic [31:0] mem [DEPTH];

  // Address decode: 33-bit compare so a window touching 2^32 cannot wrap.
  logic [32:0]   lo_bound;
  logic [32:0]   hi_bound;
  logic [31:0]   roff;
  logic [31:0]   woff;
  logic [AW-1:0] ridx;
  logic [AW-1:0] widx;
  logic          r_ok;
  logic          w_ok;
  logic          accept;
  logic          err_now;
  logic [31:0]   rd_word;
  logic          unused_bits;

  assign lo_bound = {1'b0, BASE};
  assign hi_bound = lo_bound + (33'(DEPTH) << 2);
  assign roff     = m_raddr - BASE;
  assign woff     = m_waddr - BASE;
  assign ridx     = roff[AW+1:2];
  assign widx     = woff[AW+1:2];
  assign r_ok     = ({1'b0, m_raddr} >= lo_bound) && ({1'b0, m_raddr} < hi_bound);
  assign w_ok     = ({1'b0, m_waddr} >= lo_bound) && ({1'b0, m_waddr} < hi_bound);
  assign accept   = (state == IDLE) && (m_ren || m_wen);
  assign err_now  = (m_ren && !r_ok) || (m_wen && !w_ok);
  // Array read happens before the same-edge write lands, so a combined
  // read+write to one word returns the old contents.
  assign rd_word  = (m_ren && r_ok) ? mem[ridx] : 32'h0;

  // Byte-lane bits above [3:0], sub-word address bits and offset bits beyond the array are don't-care.
  assign unused_bits = ^{m_wmask[31:4], roff[1:0], woff[1:0], roff[31:AW+2], woff[31:AW+2]};

  // Commit writes at the accept edge; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (accept && m_wen && w_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (m_wmask[i]) mem[widx][8*i +: 8] <= m_wdata[8*i +: 8];
      end
    end
  end

  // Transaction FSM with registered handshake/response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      rd_pend     <= 1'b0;
      wr_pend     <= 1'b0;
      err_pend    <= 1'b0;
      rd_buf      <= 32'h0;
      m_req_ready <= 1'b1;
      m_rvalid    <= 1'b0;
      m_bvalid    <= 1'b0;
      m_err       <= 1'b0;
      m_rdata     <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rd_pend     <= m_ren;
            wr_pend     <= m_wen;
            err_pend    <= err_now;
            rd_buf      <= rd_word;
            cnt         <= 4'(LATENCY - 1);
            m_req_ready <= 1'b0;
            if (LATENCY == 1) begin
              state    <= RESP;
              m_rvalid <= m_ren;
              m_bvalid <= m_wen;
              m_err    <= err_now;
              m_rdata  <= rd_word;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          // Counter reaching zero on this edge makes the response visible next cycle.
          if (cnt == 4'd1) begin
            state    <= RESP;
            m_rvalid <= rd_pend;
            m_bvalid <= wr_pend;
            m_err    <= err_pend;
            m_rdata  <= rd_buf;
          end
        end
        RESP: begin
          if (m_resp_ready) begin
            state       <= IDLE;
            m_req_ready <= 1'b1;
            m_rvalid    <= 1'b0;
            m_bvalid    <= 1'b0;
            m_err       <= 1'b0;
            m_rdata     <= 32'h0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
